// File: rtl/id_operand_stage.sv
// Decode/operand-fetch stage: regfile read addressing, EX/WB forwarding, load-use bubble.
// Latency 1 cycle accept->out_valid; in_ready drops on hazard, flush, reset or held entry.
module id_operand_stage #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic              in_use_rn,
    input  logic              in_use_rm,
    input  logic              in_is_load,
    input  logic              in_writes_rd,
    output logic [ADDR_W-1:0] r0addr,
    output logic [ADDR_W-1:0] r1addr,
    input  logic [DATA_W-1:0] r0data,
    input  logic [DATA_W-1:0] r1data,
    input  logic              ex_valid,
    input  logic              ex_writes,
    input  logic              ex_is_load,
    input  logic [ADDR_W-1:0] ex_waddr,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic              wb_wea,
    input  logic [ADDR_W-1:0] wb_waddr,
    input  logic [DATA_W-1:0] wb_wdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_rn_data,
    output logic [DATA_W-1:0] out_rm_data,
    output logic [ADDR_W-1:0] out_rd,
    output logic [31:0]       out_instr,
    output logic              out_is_load,
    output logic              out_writes_rd
);
    logic [ADDR_W-1:0] rn, rm, rd;
    logic              ex_fwd_ok, ex_load_busy, hazard, accept;
    logic [DATA_W-1:0] rn_res, rm_res;

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] rn_data_q, rn_data_d;
    logic [DATA_W-1:0] rm_data_q, rm_data_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [31:0]       instr_q, instr_d;
    logic              is_load_q, is_load_d;
    logic              writes_rd_q, writes_rd_d;

    assign rn = in_instr[16 +: ADDR_W];
    assign rm = in_instr[0 +: ADDR_W];
    assign rd = in_instr[12 +: ADDR_W];
    assign r0addr = rn;
    assign r1addr = rm;

    assign ex_fwd_ok    = ex_valid & ex_writes & ~ex_is_load;
    assign ex_load_busy = ex_valid & ex_writes & ex_is_load;

    // WB forwarding covers the write that lands in the regfile at this same edge.
    always_comb begin
        rn_res = r0data;
        if (ex_fwd_ok && ex_waddr == rn)
            rn_res = ex_wdata;
        else if (wb_wea && wb_waddr == rn)
            rn_res = wb_wdata;
        rm_res = r1data;
        if (ex_fwd_ok && ex_waddr == rm)
            rm_res = ex_wdata;
        else if (wb_wea && wb_waddr == rm)
            rm_res = wb_wdata;
    end

    assign hazard   = in_valid & ex_load_busy &
                      ((in_use_rn & (ex_waddr == rn)) | (in_use_rm & (ex_waddr == rm)));
    assign in_ready = ~reset & ~hazard & ~flush & (~valid_q | out_ready);
    assign accept   = in_valid & in_ready;

    always_comb begin
        valid_d     = valid_q;
        rn_data_d   = rn_data_q;
        rm_data_d   = rm_data_q;
        rd_d        = rd_q;
        instr_d     = instr_q;
        is_load_d   = is_load_q;
        writes_rd_d = writes_rd_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d     = 1'b1;
            rn_data_d   = rn_res;
            rm_data_d   = rm_res;
            rd_d        = rd;
            instr_d     = in_instr;
            is_load_d   = in_is_load;
            writes_rd_d = in_writes_rd;
        end else if (!(valid_q && !out_ready)) begin
            // Bubble: data fields keep their last values.
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q     <= 1'b0;
            rn_data_q   <= '0;
            rm_data_q   <= '0;
            rd_q        <= '0;
            instr_q     <= '0;
            is_load_q   <= 1'b0;
            writes_rd_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            rn_data_q   <= rn_data_d;
            rm_data_q   <= rm_data_d;
            rd_q        <= rd_d;
            instr_q     <= instr_d;
            is_load_q   <= is_load_d;
            writes_rd_q <= writes_rd_d;
        end
    end

    assign out_valid     = valid_q;
    assign out_rn_data   = rn_data_q;
    assign out_rm_data   = rm_data_q;
    assign out_rd        = rd_q;
    assign out_instr     = instr_q;
    assign out_is_load   = is_load_q;
    assign out_writes_rd = writes_rd_q;
endmodule

// File: tb/tb_id_operand_stage.sv
// Bench for id_operand_stage: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model with its own regfile.
module tb_id_operand_stage;
    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready;
    logic [31:0] in_instr;
    logic        in_use_rn, in_use_rm, in_is_load, in_writes_rd;
    logic [3:0]  r0addr, r1addr;
    logic [63:0] r0data, r1data;
    logic        ex_valid, ex_writes, ex_is_load;
    logic [3:0]  ex_waddr;
    logic [63:0] ex_wdata;
    logic        wb_wea;
    logic [3:0]  wb_waddr;
    logic [63:0] wb_wdata;
    logic        out_valid, out_ready;
    logic [63:0] out_rn_data, out_rm_data;
    logic [3:0]  out_rd;
    logic [31:0] out_instr;
    logic        out_is_load, out_writes_rd;

    logic [63:0] rf [16];
    assign r0data = rf[in_instr[19:16]];
    assign r1data = rf[in_instr[3:0]];

    always #5 clk = ~clk;

    id_operand_stage dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_use_rn(in_use_rn), .in_use_rm(in_use_rm),
        .in_is_load(in_is_load), .in_writes_rd(in_writes_rd),
        .r0addr(r0addr), .r1addr(r1addr), .r0data(r0data), .r1data(r1data),
        .ex_valid(ex_valid), .ex_writes(ex_writes), .ex_is_load(ex_is_load),
        .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
        .wb_wea(wb_wea), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rn_data(out_rn_data), .out_rm_data(out_rm_data), .out_rd(out_rd),
        .out_instr(out_instr), .out_is_load(out_is_load), .out_writes_rd(out_writes_rd)
    );

    int checks = 0;
    int failures = 0;

    // Model of the ID/EX register contents.
    logic        m_valid = 1'b0, m_strict = 1'b0;
    logic [63:0] m_rn = '0, m_rm = '0;
    logic [3:0]  m_rd = '0;
    logic [31:0] m_instr = '0;
    logic        m_ld = 1'b0, m_wr = 1'b0;
    logic        rdy_seen;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [63:0] operand(input logic [3:0] src);
        if (ex_valid && ex_writes && !ex_is_load && ex_waddr == src) return ex_wdata;
        if (wb_wea && wb_waddr == src) return wb_wdata;
        return rf[src];
    endfunction

    // One clock: check combinational outputs, predict, clock, then check registered outputs.
    task automatic cyc();
        logic [3:0]  rn, rm;
        logic        hz, rdy;
        logic        n_valid, n_strict, n_ld, n_wr;
        logic [63:0] n_rn, n_rm;
        logic [3:0]  n_rd;
        logic [31:0] n_instr;
        #1;
        rn = in_instr[19:16];
        rm = in_instr[3:0];
        hz = in_valid && ex_valid && ex_writes && ex_is_load &&
             ((in_use_rn && ex_waddr == rn) || (in_use_rm && ex_waddr == rm));
        rdy = !reset && !hz && !flush && (!m_valid || out_ready);
        rdy_seen = in_ready;
        chk("in_ready", {63'd0, in_ready}, {63'd0, rdy});
        chk("r0addr", {60'd0, r0addr}, {60'd0, rn});
        chk("r1addr", {60'd0, r1addr}, {60'd0, rm});
        n_valid = m_valid; n_strict = 1'b0;
        n_rn = m_rn; n_rm = m_rm; n_rd = m_rd; n_instr = m_instr; n_ld = m_ld; n_wr = m_wr;
        if (reset) begin
            n_valid = 0; n_strict = 1; n_rn = 0; n_rm = 0; n_rd = 0; n_instr = 0; n_ld = 0; n_wr = 0;
        end else if (flush) begin
            n_valid = 0;
        end else if (in_valid && rdy) begin
            n_valid = 1; n_rn = operand(rn); n_rm = operand(rm);
            n_rd = in_instr[15:12]; n_instr = in_instr; n_ld = in_is_load; n_wr = in_writes_rd;
        end else if (!(m_valid && !out_ready)) begin
            n_valid = 0;
        end
        @(posedge clk);
        #1;
        if (wb_wea) rf[wb_waddr] = wb_wdata;
        m_valid = n_valid; m_strict = n_strict;
        m_rn = n_rn; m_rm = n_rm; m_rd = n_rd; m_instr = n_instr; m_ld = n_ld; m_wr = n_wr;
        chk("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
        if (m_valid || m_strict) begin
            chk("out_rn_data", out_rn_data, m_rn);
            chk("out_rm_data", out_rm_data, m_rm);
            chk("out_rd", {60'd0, out_rd}, {60'd0, m_rd});
            chk("out_instr", {32'd0, out_instr}, {32'd0, m_instr});
            chk("out_flags", {62'd0, out_is_load, out_writes_rd}, {62'd0, m_ld, m_wr});
        end
    endtask

    task automatic idle_all();
        reset = 0; flush = 0; in_valid = 0; in_instr = 0;
        in_use_rn = 0; in_use_rm = 0; in_is_load = 0; in_writes_rd = 0;
        ex_valid = 0; ex_writes = 0; ex_is_load = 0; ex_waddr = 0; ex_wdata = 0;
        wb_wea = 0; wb_waddr = 0; wb_wdata = 0; out_ready = 1;
    endtask

    task automatic set_instr(input logic [3:0] rn, input logic [3:0] rm, input logic [3:0] rd,
                             input logic urn, input logic urm);
        logic [31:0] w;
        w = $urandom;
        w[19:16] = rn; w[3:0] = rm; w[15:12] = rd;
        in_instr = w; in_use_rn = urn; in_use_rm = urm; in_valid = 1;
    endtask

    initial begin
        logic [31:0] held, next_i;
        for (int i = 0; i < 16; i++) rf[i] = 64'd0;
        rf[1] = 64'h5;
        idle_all();

        // Reset with a valid input pending.
        reset = 1;
        set_instr(4'd1, 4'd0, 4'd9, 1, 0);
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk("rst_in_ready", {63'd0, rdy_seen}, 64'd0);
            chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
            chk("rst_out_rn", out_rn_data, 64'd0);
        end
        reset = 0;
        cyc();
        chk("first_accept_rdy", {63'd0, rdy_seen}, 64'd1);
        chk("first_accept_valid", {63'd0, out_valid}, 64'd1);
        chk("first_accept_rn", out_rn_data, 64'h5);

        // EX forwarding beats a stale regfile value.
        ex_valid = 1; ex_writes = 1; ex_is_load = 0; ex_waddr = 4'd3; ex_wdata = 64'h1234;
        set_instr(4'd3, 4'd0, 4'd4, 1, 0);
        cyc();
        chk("ex_fwd_rn", out_rn_data, 64'h1234);

        // EX has priority over WB; WB used once EX is gone.
        ex_waddr = 4'd5; ex_wdata = 64'hAA;
        wb_wea = 1; wb_waddr = 4'd5; wb_wdata = 64'hBB;
        set_instr(4'd0, 4'd5, 4'd6, 0, 1);
        cyc();
        chk("ex_over_wb_rm", out_rm_data, 64'hAA);
        ex_valid = 0;
        cyc();
        chk("wb_fwd_rm", out_rm_data, 64'hBB);

        // Load-use: one bubble, then WB supplies the loaded value.
        wb_wea = 0;
        ex_valid = 1; ex_writes = 1; ex_is_load = 1; ex_waddr = 4'd2; ex_wdata = 64'hDEAD;
        set_instr(4'd2, 4'd1, 4'd7, 1, 0);
        cyc();
        chk("lu_in_ready", {63'd0, rdy_seen}, 64'd0);
        chk("lu_bubble", {63'd0, out_valid}, 64'd0);
        ex_valid = 0; wb_wea = 1; wb_waddr = 4'd2; wb_wdata = 64'h77;
        cyc();
        chk("lu_accept_valid", {63'd0, out_valid}, 64'd1);
        chk("lu_accept_rn", out_rn_data, 64'h77);

        // Backpressure holds the entry for three cycles.
        wb_wea = 0; out_ready = 0;
        held = out_instr;
        set_instr(4'd7, 4'd8, 4'd9, 1, 1);
        next_i = in_instr;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("bp_in_ready", {63'd0, rdy_seen}, 64'd0);
            chk("bp_valid", {63'd0, out_valid}, 64'd1);
            chk("bp_rn_stable", out_rn_data, 64'h77);
            chk("bp_instr_stable", {32'd0, out_instr}, {32'd0, held});
        end
        out_ready = 1;
        cyc();
        chk("bp_release_instr", {32'd0, out_instr}, {32'd0, next_i});

        // Flush kills the held entry and the input.
        out_ready = 0; flush = 1;
        set_instr(4'd1, 4'd1, 4'd1, 1, 1);
        cyc();
        chk("flush_valid", {63'd0, out_valid}, 64'd0);
        flush = 0; out_ready = 1;
        cyc();
        chk("refill_valid", {63'd0, out_valid}, 64'd1);
        flush = 1; reset = 1; out_ready = 0;
        cyc();
        chk("flush_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_rst_rn", out_rn_data, 64'd0);
        chk("flush_rst_instr", {32'd0, out_instr}, 64'd0);

        // Randomized traffic over a small register window to make matches frequent.
        idle_all();
        for (int i = 0; i < 16; i++) rf[i] = {$urandom, $urandom};
        for (int n = 0; n < 4000; n++) begin
            reset = ($urandom_range(0, 99) < 2);
            flush = ($urandom_range(0, 99) < 8);
            out_ready = ($urandom_range(0, 99) < 70);
            set_instr(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom),
                      1'($urandom), 1'($urandom));
            in_valid = ($urandom_range(0, 99) < 80);
            in_is_load = 1'($urandom); in_writes_rd = 1'($urandom);
            ex_valid = 1'($urandom); ex_writes = 1'($urandom);
            ex_is_load = ($urandom_range(0, 99) < 30);
            ex_waddr = 4'($urandom_range(0, 3)); ex_wdata = {$urandom, $urandom};
            wb_wea = 1'($urandom); wb_waddr = 4'($urandom_range(0, 3));
            wb_wdata = {$urandom, $urandom};
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
